shift_engine_nbit: RTL
======================

SHIFT_ENGINE_NBIT -- requirements
Module: shift_engine_nbit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width in bits (minimum 2).
REQ-002 SHALL provide parameter AMT_W, default 4, width of the shift-amount port.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin an operation, sampled on clk rising edge.
REQ-006 SHALL have port x  input  WIDTH  operand, captured when start is accepted.
REQ-007 SHALL have port mode  input  2  operation: 00 logical right (SRL), 01 logical left (SLL), 10 arithmetic right (SRA), 11 rotate right (ROR); captured with x.
REQ-008 SHALL have port amt  input  AMT_W  number of single-bit shift steps; captured with x.
REQ-009 SHALL have port f  output  WIDTH  result register.
REQ-010 SHALL have port cout  output  1  last bit shifted or rotated out.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement the states IDLE, SHIFT and DONE.
REQ-014 SHALL accept start only in IDLE; on the accepting edge, it SHALL load f<=x, cout<=0 and a counter<=amt.
REQ-015 On acceptance, the next state SHALL be SHIFT if amt!=0, and DONE if amt==0.
REQ-016 Each SHIFT cycle SHALL perform exactly one 1-bit step on f, update cout, and decrement the counter.
REQ-017 The SHIFT state SHALL move to DONE on the edge where the counter goes from 1 to 0.
REQ-018 SRL step SHALL be: cout<=f[0], f<={0,f[WIDTH-1:1]}.
REQ-019 SLL step SHALL be: cout<=f[WIDTH-1], f<={f[WIDTH-2:0],0}.
REQ-020 SRA step SHALL be: cout<=f[0], f<={f[WIDTH-1],f[WIDTH-1:1]}.
REQ-021 ROR step SHALL be: cout<=f[0], f<={f[0],f[WIDTH-1:1]}.
REQ-022 In DONE, done SHALL be high for exactly one cycle, after which the state SHALL return to IDLE unconditionally.
REQ-023 If start is accepted at edge E0, done SHALL be high in the cycle after edge E(amt+1), so latency is amt+1 cycles.
REQ-024 f and cout SHALL be valid while done is high, and SHALL hold that value in IDLE until the next accepted start.
REQ-025 start asserted in SHIFT or DONE SHALL be ignored, with no queuing; x, mode and amt changes during busy SHALL have no effect.
REQ-026 amt>=WIDTH SHALL be legal and SHALL iterate the full count.
REQ-027 With amt>=WIDTH, SRL/SLL SHALL yield all-zero, SRA SHALL yield the sign fill, and ROR SHALL wrap modulo WIDTH.
REQ-028 With amt==0, f SHALL equal x and cout SHALL be 0.
REQ-029 start held high continuously SHALL be accepted again in the IDLE cycle following DONE.

Reset
REQ-030 On rst high, regardless of clk, the block SHALL force state=IDLE, f=0, cout=0, busy=0, done=0 and counter=0.
REQ-031 rst asserted mid-operation SHALL abort the operation and produce no done pulse.
REQ-032 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8, AMT_W=4)
REQ-033 The bench SHALL cover: x=11111101, SRL, amt=1 -> done 2 cycles after start edge, f=01111110, cout=1.
REQ-034 The bench SHALL cover: x=10001110, SRA, amt=3 -> busy for 4 cycles, then f=11110001, cout=1.
REQ-035 The bench SHALL cover: x=11001101, ROR, amt=2 -> f=01110011, cout=0; the same x with amt=8 -> f=11001101, cout=1.
REQ-036 The bench SHALL cover: x=10001111, SLL, amt=8 -> f=00000000, cout=1; the same x with SRL, amt=0 -> f=10001111, cout=0, done 1 cycle after start.
REQ-037 The bench SHALL cover: start SRL amt=5, re-pulse start with new x at cycle 2 -> ignored, and the original result is returned at cycle 6.
REQ-038 The bench SHALL cover: start SRA amt=7, assert rst asynchronously between edges at cycle 3 -> f=0, busy=0 immediately, and no done pulse.

Source files
------------

// File: rtl/shift_engine_nbit.sv
// shift_engine_nbit: multi-cycle 1-bit-per-cycle shifter/rotator (SRL, SLL, SRA, ROR) with busy/done handshake.
module shift_engine_nbit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d, step;
  logic             cout_q, cout_d, fill;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  always_comb begin
    fill    = mode_q == 2'b10 ? f_q[WIDTH-1] : mode_q == 2'b11 ? f_q[0] : 1'b0;
    step    = mode_q == 2'b01 ? {f_q[WIDTH-2:0], 1'b0} : {fill, f_q[WIDTH-1:1]};
    state_d = state_q;
    f_d     = f_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (state_q == IDLE && start) begin
      f_d     = x;
      cout_d  = 1'b0;
      cnt_d   = amt;
      mode_d  = mode;
      state_d = amt != '0 ? SHIFT : DONE;
    end else if (state_q == SHIFT) begin
      f_d     = step;
      cout_d  = mode_q == 2'b01 ? f_q[WIDTH-1] : f_q[0];
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == AMT_W'(1) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  assign f    = f_q;
  assign cout = cout_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
